// File: rtl/test_proto_pkg.sv
// test_proto_pkg: protocol definitions shared by the test fabric endpoints.
//   - op_e / status_e       : request opcodes and response status codes
//   - HDR_*_LSB             : bit offsets of the header fields
//   - state_e               : responder FSM state encoding
//   - pack_rsp_hdr()        : builds a 64-bit response header (all unused bits 0)
package test_proto_pkg;

  typedef enum logic [7:0] {
    OP_ECHO = 8'h01,
    OP_SUM  = 8'h02
  } op_e;

  typedef enum logic [1:0] {
    ST_OK           = 2'd0,
    ST_BAD_OP       = 2'd1,
    ST_LEN_MISMATCH = 2'd2,
    ST_OVERFLOW     = 2'd3
  } status_e;

  // Request header: op, len, src, tag. Response header: op, rlen, id, status, tag.
  localparam int HDR_OP_LSB     = 0;
  localparam int HDR_LEN_LSB    = 8;
  localparam int HDR_SRC_LSB    = 16;
  localparam int HDR_ID_LSB     = 16;
  localparam int HDR_STATUS_LSB = 18;
  localparam int HDR_TAG_LSB    = 32;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_RECV     = 2'd1,
    S_RSP_HDR  = 2'd2,
    S_RSP_DATA = 2'd3
  } state_e;

  function automatic logic [63:0] pack_rsp_hdr(input logic [7:0]  op,
                                               input logic [7:0]  rlen,
                                               input logic [1:0]  id,
                                               input status_e     status,
                                               input logic [31:0] tag);
    logic [63:0] h;
    h = '0;
    h[HDR_OP_LSB +: 8]     = op;
    h[HDR_LEN_LSB +: 8]    = rlen;
    h[HDR_ID_LSB +: 2]     = id;
    h[HDR_STATUS_LSB +: 2] = status;
    h[HDR_TAG_LSB +: 32]   = tag;
    return h;
  endfunction

endpackage

// File: rtl/test_responder_if.sv
// test_responder_if: one AXI-Stream channel (tdata/tvalid/tready/tlast/tdest).
//   master modport: drives tdata, tvalid, tlast, tdest; samples tready
//   slave  modport: samples tdata, tvalid, tlast, tdest; drives tready
interface test_responder_if #(
  parameter int DATA_WIDTH = 64
);
  logic [DATA_WIDTH-1:0] tdata;
  logic                  tvalid;
  logic                  tready;
  logic                  tlast;
  logic [1:0]            tdest;

  modport master (output tdata, output tvalid, output tlast, output tdest, input tready);
  modport slave  (input tdata, input tvalid, input tlast, input tdest, output tready);
endinterface

// File: rtl/payload_buffer.sv
// payload_buffer: DEPTH x DATA_WIDTH single-clock FIFO holding ECHO payload.
//   aclk, areset : clock, asynchronous active-high reset (pointers/count to 0)
//   flush        : synchronous empty; takes priority over wr_en/rd_en
//   wr_en/wr_data: push (ignored when full)
//   rd_en        : pop (ignored when empty)
//   rd_data      : head-of-queue word, valid whenever count > 0
//   count        : number of stored words
// The head word is read combinationally so the responder can load it into
// its output register on the same edge as the previous handshake, which is
// what keeps response beats back-to-back.
module payload_buffer #(
  parameter int DATA_WIDTH = 64,
  parameter int DEPTH      = 16
) (
  input  logic                          aclk,
  input  logic                          areset,
  input  logic                          flush,
  input  logic                          wr_en,
  input  logic [DATA_WIDTH-1:0]         wr_data,
  input  logic                          rd_en,
  output logic [DATA_WIDTH-1:0]         rd_data,
  output logic [$clog2(DEPTH+1)-1:0]    count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_wr, do_rd;

  assign do_wr = wr_en && (count_q != CW'(DEPTH)) && !flush;
  assign do_rd = rd_en && (count_q != '0) && !flush;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      // DEPTH is a power of two, so pointers wrap naturally.
      if (do_wr) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_rd) rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + CW'(do_wr) - CW'(do_rd);
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage itself needs no reset: emptiness is tracked by the pointers.
  always_ff @(posedge aclk) begin
    if (do_wr) mem[wr_ptr_q] <= wr_data;
  end

  assign rd_data = mem[rd_ptr_q];
  assign count   = count_q;
endmodule

// File: rtl/test_responder.sv
// test_responder: AXI-Stream endpoint executing ECHO / SUM requests and
// returning one response packet per request, routed back via m_axis.tdest.
//   aclk, areset : clock, asynchronous active-high reset
//   s_axis       : request stream (slave); tdest is ignored
//   m_axis       : response stream (master); all outputs registered
// Parameters: DATA_WIDTH (>= 64), DEPTH (ECHO buffer beats, power of two),
// MY_ID (reported in response headers).
module test_responder
  import test_proto_pkg::*;
#(
  parameter int         DATA_WIDTH = 64,
  parameter int         DEPTH      = 16,
  parameter logic [1:0] MY_ID      = 2'd0
) (
  input  logic               aclk,
  input  logic               areset,
  test_responder_if.slave    s_axis,
  test_responder_if.master   m_axis
);
  localparam int CW = $clog2(DEPTH + 1);

  state_e                state_q, state_d;
  logic                  s_ready_q, s_ready_d;
  logic                  m_valid_q, m_valid_d;
  logic                  m_last_q, m_last_d;
  logic [DATA_WIDTH-1:0] m_data_q, m_data_d;
  logic [1:0]            m_dest_q, m_dest_d;
  logic [7:0]            op_q, op_d;
  logic [7:0]            len_q, len_d;
  logic [1:0]            src_q, src_d;
  logic [31:0]           tag_q, tag_d;
  logic [8:0]            cnt_q, cnt_d;     // saturates so >255 beats never alias len
  logic [DATA_WIDTH-1:0] sum_q, sum_d;
  logic [7:0]            rlen_q, rlen_d;
  logic [7:0]            left_q, left_d;   // data beats still to load after the current one
  logic                  is_sum_q, is_sum_d;

  logic                  buf_flush, buf_wr, buf_rd;
  logic [DATA_WIDTH-1:0] buf_rd_data;
  logic [CW-1:0]         buf_count;

  logic                  s_hs, m_hs, in_idle, go_rsp;
  logic [7:0]            cur_op, cur_len;
  logic [1:0]            cur_src;
  logic [31:0]           cur_tag;
  logic [8:0]            cnt_inc, fin_cnt;
  logic [DATA_WIDTH-1:0] fin_sum;
  logic [7:0]            fin_rlen;
  status_e               fin_status;

  payload_buffer #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(DEPTH)) u_buf (
    .aclk    (aclk),
    .areset  (areset),
    .flush   (buf_flush),
    .wr_en   (buf_wr),
    .wr_data (s_axis.tdata),
    .rd_en   (buf_rd),
    .rd_data (buf_rd_data),
    .count   (buf_count)
  );

  assign s_hs    = s_axis.tvalid && s_ready_q;
  assign m_hs    = m_valid_q && m_axis.tready;
  assign in_idle = (state_q == S_IDLE);

  // When tlast arrives on the header beat, the header fields are still on
  // the bus rather than in the registers.
  assign cur_op  = in_idle ? s_axis.tdata[HDR_OP_LSB +: 8]  : op_q;
  assign cur_len = in_idle ? s_axis.tdata[HDR_LEN_LSB +: 8] : len_q;
  assign cur_src = in_idle ? s_axis.tdata[HDR_SRC_LSB +: 2] : src_q;
  assign cur_tag = in_idle ? s_axis.tdata[HDR_TAG_LSB +: 32] : tag_q;
  assign cnt_inc = (cnt_q == 9'h1FF) ? cnt_q : cnt_q + 9'd1;
  assign fin_cnt = in_idle ? 9'd0 : cnt_inc;
  assign fin_sum = in_idle ? '0 : sum_q + s_axis.tdata;

  always_comb begin
    fin_status = ST_OK;
    if (cur_op != OP_ECHO && cur_op != OP_SUM)        fin_status = ST_BAD_OP;
    else if (fin_cnt != {1'b0, cur_len})              fin_status = ST_LEN_MISMATCH;
    else if (cur_op == OP_ECHO && cur_len > 8'(DEPTH)) fin_status = ST_OVERFLOW;
    fin_rlen = 8'd0;
    if (fin_status == ST_OK) fin_rlen = (cur_op == OP_SUM) ? 8'd1 : cur_len;
  end

  always_comb begin
    state_d   = state_q;
    m_valid_d = m_valid_q;
    m_last_d  = m_last_q;
    m_data_d  = m_data_q;
    m_dest_d  = m_dest_q;
    op_d      = op_q;
    len_d     = len_q;
    src_d     = src_q;
    tag_d     = tag_q;
    cnt_d     = cnt_q;
    sum_d     = sum_q;
    rlen_d    = rlen_q;
    left_d    = left_q;
    is_sum_d  = is_sum_q;
    buf_flush = 1'b0;
    buf_wr    = 1'b0;
    buf_rd    = 1'b0;
    go_rsp    = 1'b0;

    unique case (state_q)
      S_IDLE: if (s_hs) begin
        op_d      = cur_op;
        len_d     = cur_len;
        src_d     = cur_src;
        tag_d     = cur_tag;
        cnt_d     = 9'd0;
        sum_d     = '0;
        buf_flush = 1'b1;  // drop leftovers of an earlier errored request
        if (s_axis.tlast) go_rsp = 1'b1;
        else              state_d = S_RECV;
      end
      S_RECV: if (s_hs) begin
        cnt_d  = cnt_inc;
        sum_d  = fin_sum;
        buf_wr = (cnt_q < 9'(DEPTH));
        if (s_axis.tlast) go_rsp = 1'b1;
      end
      S_RSP_HDR: if (m_hs) begin
        if (rlen_q == 8'd0) begin
          state_d   = S_IDLE;
          m_valid_d = 1'b0;
          m_last_d  = 1'b0;
          m_data_d  = '0;
        end else begin
          state_d  = S_RSP_DATA;
          m_data_d = is_sum_q ? sum_q : buf_rd_data;
          buf_rd   = !is_sum_q;
          left_d   = rlen_q - 8'd1;
          m_last_d = (rlen_q == 8'd1);
        end
      end
      S_RSP_DATA: if (m_hs) begin
        if (left_q == 8'd0) begin
          state_d   = S_IDLE;
          m_valid_d = 1'b0;
          m_last_d  = 1'b0;
          m_data_d  = '0;
        end else begin
          m_data_d = buf_rd_data;
          buf_rd   = 1'b1;
          left_d   = left_q - 8'd1;
          m_last_d = (left_q == 8'd1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (go_rsp) begin
      state_d   = S_RSP_HDR;
      m_valid_d = 1'b1;
      m_data_d  = DATA_WIDTH'(pack_rsp_hdr(cur_op, fin_rlen, MY_ID, fin_status, cur_tag));
      m_last_d  = (fin_rlen == 8'd0);
      m_dest_d  = cur_src;
      rlen_d    = fin_rlen;
      sum_d     = fin_sum;
      is_sum_d  = (cur_op == OP_SUM);
    end
  end

  // Ready is decoded from the next state so it is a clean register output;
  // it is therefore low during the cycle of the final response handshake.
  assign s_ready_d = (state_d == S_IDLE) || (state_d == S_RECV);

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q   <= S_IDLE;
      s_ready_q <= 1'b0;
      m_valid_q <= 1'b0;
      m_last_q  <= 1'b0;
      m_data_q  <= '0;
      m_dest_q  <= 2'd0;
      op_q      <= 8'd0;
      len_q     <= 8'd0;
      src_q     <= 2'd0;
      tag_q     <= 32'd0;
      cnt_q     <= 9'd0;
      sum_q     <= '0;
      rlen_q    <= 8'd0;
      left_q    <= 8'd0;
      is_sum_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      s_ready_q <= s_ready_d;
      m_valid_q <= m_valid_d;
      m_last_q  <= m_last_d;
      m_data_q  <= m_data_d;
      m_dest_q  <= m_dest_d;
      op_q      <= op_d;
      len_q     <= len_d;
      src_q     <= src_d;
      tag_q     <= tag_d;
      cnt_q     <= cnt_d;
      sum_q     <= sum_d;
      rlen_q    <= rlen_d;
      left_q    <= left_d;
      is_sum_q  <= is_sum_d;
    end
  end

  assign s_axis.tready = s_ready_q;
  assign m_axis.tvalid = m_valid_q;
  assign m_axis.tlast  = m_last_q;
  assign m_axis.tdata  = m_data_q;
  assign m_axis.tdest  = m_dest_q;

  logic unused_ok;
  assign unused_ok = ^{s_axis.tdest, buf_count};
endmodule

// File: tb/tb_test_responder.sv
// tb_test_responder: directed self-checking bench for test_responder.
module tb_test_responder;
  logic aclk = 1'b0;
  logic areset = 1'b1;
  always #5 aclk = ~aclk;

  test_responder_if #(.DATA_WIDTH(64)) s_if ();
  test_responder_if #(.DATA_WIDTH(64)) m_if ();

  test_responder #(.DATA_WIDTH(64), .DEPTH(16), .MY_ID(2'd0)) dut (
    .aclk   (aclk),
    .areset (areset),
    .s_axis (s_if),
    .m_axis (m_if)
  );

  int n_cmp = 0;
  int n_err = 0;

  function automatic void chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endfunction

  task automatic send_beat(input string tag, input logic [63:0] d, input logic l);
    int n;
    n = 0;
    @(negedge aclk);
    s_if.tvalid = 1'b1;
    s_if.tdata  = d;
    s_if.tlast  = l;
    while (s_if.tready !== 1'b1 && n < 40) begin
      @(negedge aclk);
      n++;
    end
    if (n >= 40) chk({tag, " accept timeout"}, 64'(n), 64'd0);
    @(posedge aclk);
    #1;
    s_if.tvalid = 1'b0;
    s_if.tlast  = 1'b0;
  endtask

  task automatic check_beat(input string tag, input logic [63:0] d, input logic l, input logic [1:0] dest);
    int n;
    n = 0;
    @(negedge aclk);
    while (m_if.tvalid !== 1'b1 && n < 40) begin
      @(negedge aclk);
      n++;
    end
    $display("rsp %s: data=%016h last=%0b dest=%0d wait=%0d", tag, m_if.tdata, m_if.tlast, m_if.tdest, n);
    chk({tag, " wait"}, 64'(n), 64'd0);
    chk({tag, " data"}, m_if.tdata, d);
    chk({tag, " last"}, 64'(m_if.tlast), 64'(l));
    chk({tag, " dest"}, 64'(m_if.tdest), 64'(dest));
  endtask

  task automatic check_idle(input string tag);
    @(negedge aclk);
    chk({tag, " idle tvalid"}, 64'(m_if.tvalid), 64'd0);
    chk({tag, " idle s_tready"}, 64'(s_if.tready), 64'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1, "watchdog");
  end

  logic [63:0] bp_exp [3];
  logic        bp_last [3];
  int          g;

  initial begin
    m_if.tready = 1'b1;
    s_if.tvalid = 1'b0;
    s_if.tdata  = '0;
    s_if.tlast  = 1'b0;
    s_if.tdest  = 2'd0;
    areset      = 1'b1;

    // Reset state
    repeat (2) @(negedge aclk);
    chk("reset s_tready", 64'(s_if.tready), 64'd0);
    chk("reset m_tvalid", 64'(m_if.tvalid), 64'd0);
    chk("reset m_tlast",  64'(m_if.tlast),  64'd0);
    chk("reset m_tdata",  m_if.tdata,       64'd0);
    chk("reset m_tdest",  64'(m_if.tdest),  64'd0);
    areset = 1'b0;
    @(negedge aclk);
    chk("s_tready after reset", 64'(s_if.tready), 64'd1);

    // ECHO len 3, src 2
    send_beat("echo3 hdr", 64'hCAFE0001_0002_0301, 1'b0);
    send_beat("echo3 p0", 64'h11, 1'b0);
    send_beat("echo3 p1", 64'h22, 1'b0);
    send_beat("echo3 p2", 64'h33, 1'b1);
    check_beat("echo3 hdr", 64'hCAFE0001_0000_0301, 1'b0, 2'd2);
    check_beat("echo3 d0", 64'h11, 1'b0, 2'd2);
    check_beat("echo3 d1", 64'h22, 1'b0, 2'd2);
    check_beat("echo3 d2", 64'h33, 1'b1, 2'd2);
    check_idle("echo3");

    // SUM with wrap-around
    send_beat("sum hdr", 64'h00000002_0001_0202, 1'b0);
    send_beat("sum p0", 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    send_beat("sum p1", 64'h2, 1'b1);
    check_beat("sum hdr", 64'h00000002_0000_0102, 1'b0, 2'd1);
    check_beat("sum d0", 64'h1, 1'b1, 2'd1);
    check_idle("sum");

    // Bad opcode, then a normal header-only SUM (len 0)
    send_beat("badop hdr", 64'h12345678_0003_0107, 1'b0);
    send_beat("badop p0", 64'h99, 1'b1);
    check_beat("badop hdr", 64'h12345678_0004_0007, 1'b1, 2'd3);
    check_idle("badop");
    send_beat("sum0 hdr", 64'h0000000A_0000_0002, 1'b1);
    check_beat("sum0 hdr", 64'h0000000A_0000_0102, 1'b0, 2'd0);
    check_beat("sum0 d0", 64'h0, 1'b1, 2'd0);
    check_idle("sum0");

    // Length mismatch: len 4, tlast on 2nd payload beat
    send_beat("lenmis hdr", 64'h00000044_0001_0401, 1'b0);
    send_beat("lenmis p0", 64'h0A, 1'b0);
    send_beat("lenmis p1", 64'h0B, 1'b1);
    check_beat("lenmis hdr", 64'h00000044_0008_0001, 1'b1, 2'd1);
    check_idle("lenmis");

    // Overflow: ECHO len 20 with 20 beats
    send_beat("ovf hdr", 64'h00000055_0002_1401, 1'b0);
    for (int i = 0; i < 20; i++) send_beat("ovf p", 64'h500 + 64'(i), (i == 19));
    check_beat("ovf hdr", 64'h00000055_000C_0001, 1'b1, 2'd2);
    check_idle("ovf");

    // ECHO exactly DEPTH beats
    send_beat("echo16 hdr", 64'h00000016_0000_1001, 1'b0);
    for (int i = 0; i < 16; i++) send_beat("echo16 p", 64'h100 + 64'(i), (i == 15));
    check_beat("echo16 hdr", 64'h00000016_0000_1001, 1'b0, 2'd0);
    for (int i = 0; i < 16; i++) check_beat("echo16 d", 64'h100 + 64'(i), (i == 15), 2'd0);
    check_idle("echo16");

    // Backpressure: ECHO len 2, src 3, with stalls before each handshake
    bp_exp[0] = 64'h000000BB_0000_0201; bp_last[0] = 1'b0;
    bp_exp[1] = 64'hA1;                 bp_last[1] = 1'b0;
    bp_exp[2] = 64'hA2;                 bp_last[2] = 1'b1;
    m_if.tready = 1'b0;
    send_beat("bp hdr", 64'h000000BB_0003_0201, 1'b0);
    send_beat("bp p0", 64'hA1, 1'b0);
    send_beat("bp p1", 64'hA2, 1'b1);
    for (int k = 0; k < 3; k++) begin
      g = $urandom_range(1, 3);
      for (int s = 0; s < g; s++) begin
        @(negedge aclk);
        chk("bp stall tvalid", 64'(m_if.tvalid), 64'd1);
        chk("bp stall tdata", m_if.tdata, bp_exp[k]);
        chk("bp stall tlast", 64'(m_if.tlast), 64'(bp_last[k]));
        chk("bp stall tdest", 64'(m_if.tdest), 64'd3);
        chk("bp stall s_tready", 64'(s_if.tready), 64'd0);
      end
      @(negedge aclk);
      m_if.tready = 1'b1;
      $display("rsp bp beat %0d: data=%016h last=%0b stall=%0d", k, m_if.tdata, m_if.tlast, g);
      chk("bp hs tdata", m_if.tdata, bp_exp[k]);
      chk("bp hs s_tready", 64'(s_if.tready), 64'd0);
      @(posedge aclk);
      #1;
      m_if.tready = 1'b0;
    end
    m_if.tready = 1'b1;
    check_idle("bp");

    // Reset during RSP_DATA of ECHO len 4
    send_beat("rst hdr", 64'h00000077_0001_0401, 1'b0);
    for (int i = 0; i < 4; i++) send_beat("rst p", 64'hD1 + 64'(i), (i == 3));
    check_beat("rst hdr", 64'h00000077_0000_0401, 1'b0, 2'd1);
    check_beat("rst d0", 64'hD1, 1'b0, 2'd1);
    @(negedge aclk);
    chk("rst pre tvalid", 64'(m_if.tvalid), 64'd1);
    areset = 1'b1;
    #1;
    $display("reset asserted mid-response: tvalid=%0b", m_if.tvalid);
    chk("rst tvalid drop", 64'(m_if.tvalid), 64'd0);
    chk("rst tdata clear", m_if.tdata, 64'd0);
    chk("rst s_tready", 64'(s_if.tready), 64'd0);
    repeat (2) @(negedge aclk);
    areset = 1'b0;
    @(negedge aclk);
    chk("post-rst s_tready", 64'(s_if.tready), 64'd1);
    chk("post-rst tvalid", 64'(m_if.tvalid), 64'd0);
    send_beat("new hdr", 64'h00000088_0000_0101, 1'b0);
    send_beat("new p0", 64'hE1, 1'b1);
    check_beat("new hdr", 64'h00000088_0000_0101, 1'b0, 2'd0);
    check_beat("new d0", 64'hE1, 1'b1, 2'd0);
    check_idle("new");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
